// File: rtl/game_ctrl_pkg.sv
// game_ctrl_pkg
// Shared definitions for the goose-run game controller: run-state encodings,
// datapath widths, default timing constants and the terminal-count helper.
// No ports (package).

package game_ctrl_pkg;

    localparam int STATE_W = 2;
    localparam int LEVEL_W = 4;
    localparam int DIV_W   = 28;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    // 100 MHz clock: level 0 gives a 25 Hz tick, floor gives 100 Hz.
    localparam int DEF_BASE_DIV        = 4000000;
    localparam int DEF_DIV_STEP        = 250000;
    localparam int DEF_MIN_DIV         = 1000000;
    localparam int DEF_TICKS_PER_LEVEL = 250;
    localparam int DEF_MAX_LEVEL       = 12;
    localparam int DEF_GRACE_TICKS     = 25;

    // term = max(base_div - lvl*div_step, min_div). The reduction is compared
    // against the headroom first so the subtraction can never wrap.
    function automatic logic [DIV_W-1:0] calc_term(
        input logic [LEVEL_W-1:0] lvl,
        input int                 base_div,
        input int                 div_step,
        input int                 min_div
    );
        logic [DIV_W-1:0] reduce;
        logic [DIV_W-1:0] headroom;
        if (base_div <= min_div) begin
            return DIV_W'(min_div);
        end
        reduce   = DIV_W'(lvl) * DIV_W'(div_step);
        headroom = DIV_W'(base_div) - DIV_W'(min_div);
        if (reduce >= headroom) begin
            return DIV_W'(min_div);
        end
        return DIV_W'(base_div) - reduce;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider
// Programmable terminal-count divider. While en is high the counter advances
// once per cycle; on reaching term it wraps to 0 and raises tick for exactly
// one cycle, so tick spacing is term+1 enabled cycles. With en low the count
// holds and tick is 0.
// Ports:
//   clk_in  in   clock
//   reset   in   synchronous active-high reset
//   en      in   count enable
//   clr     in   synchronous clear of count and tick
//   term    in   terminal count (DIV_W bits)
//   tick    out  registered one-cycle strobe
//   fire    out  combinational: the current edge will issue a tick

module tick_divider
    import game_ctrl_pkg::*;
(
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] term,
    output logic             tick,
    output logic             fire
);

    logic [DIV_W-1:0] cnt;

    assign fire = en && (cnt == term);

    always_ff @(posedge clk_in) begin
        if (reset || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            cnt  <= fire ? '0 : cnt + DIV_W'(1);
            tick <= fire;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/game_tick_ctrl.sv
// game_tick_ctrl
// Run-state controller and level-scaled game-tick generator for goose-run.
// The tick period shrinks by DIV_STEP per level down to MIN_DIV; the level
// advances every TICKS_PER_LEVEL ticks and saturates at MAX_LEVEL.
// Optional build macro GAME_GRACE_PERIOD_EN: collisions are ignored for the
// first GRACE_TICKS ticks after each start.
// Ports:
//   clk_in     in   clock, 100 MHz
//   reset      in   synchronous active-high reset
//   start      in   one-cycle start pulse
//   pause      in   one-cycle pause-toggle pulse
//   collision  in   goose/obstacle overlap level
//   tick       out  one-cycle game-tick strobe
//   level_up   out  one-cycle strobe, coincident with the tick that levels up
//   level      out  current level 0..MAX_LEVEL
//   state      out  0=IDLE 1=RUN 2=PAUSE 3=OVER
//   running    out  high iff state==RUN
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | divider counting, ticks issued, collisions live
// ST_PAUSE | divider, tick count and grace count frozen
// ST_OVER  | collision ended the game, waiting for start

module game_tick_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int BASE_DIV        = DEF_BASE_DIV,
    parameter int DIV_STEP        = DEF_DIV_STEP,
    parameter int MIN_DIV         = DEF_MIN_DIV,
    parameter int TICKS_PER_LEVEL = DEF_TICKS_PER_LEVEL,
    parameter int MAX_LEVEL       = DEF_MAX_LEVEL,
    parameter int GRACE_TICKS     = DEF_GRACE_TICKS
)
(
    input  logic               clk_in,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               collision,
    output logic               tick,
    output logic               level_up,
    output logic [LEVEL_W-1:0] level,
    output logic [STATE_W-1:0] state,
    output logic               running
);

    localparam int TCNT_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

    if (GRACE_TICKS < 0) begin : g_bad_grace
        $error("GRACE_TICKS must be non-negative");
    end

    game_state_t        state_q;
    game_state_t        state_d;
    logic               coll_act;
    logic               div_en;
    logic               div_clr;
    logic               fire;
    logic [DIV_W-1:0]   term;
    logic [TCNT_W-1:0]  tcnt;

    assign term = calc_term(level, BASE_DIV, DIV_STEP, MIN_DIV);

`ifdef GAME_GRACE_PERIOD_EN
    localparam int GRACE_W = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;
    logic [GRACE_W-1:0] grace_cnt;

    // Advances only on issued ticks, so a pause freezes it for free.
    always_ff @(posedge clk_in) begin
        if (reset || div_clr) begin
            grace_cnt <= '0;
        end else if (fire && (grace_cnt < GRACE_W'(GRACE_TICKS))) begin
            grace_cnt <= grace_cnt + GRACE_W'(1);
        end
    end

    assign coll_act = collision && (grace_cnt >= GRACE_W'(GRACE_TICKS));
`else
    assign coll_act = collision;
`endif

    // State register; running is derived from the next state so it shares the edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= ST_IDLE;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= (state_d == ST_RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE,
            ST_OVER:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (coll_act)   state_d = ST_OVER;
                else if (pause) state_d = ST_PAUSE;
            end
            ST_PAUSE: if (pause) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A collision or pause in RUN suppresses counting in that same cycle,
    // which also blocks a tick that would otherwise land on it.
    always_comb begin
        div_en  = (state_q == ST_RUN) && !coll_act && !pause;
        div_clr = ((state_q == ST_IDLE) || (state_q == ST_OVER)) && start;
    end

    assign state = state_q;

    tick_divider u_div (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (div_en),
        .clr    (div_clr),
        .term   (term),
        .tick   (tick),
        .fire   (fire)
    );

    always_ff @(posedge clk_in) begin
        if (reset || div_clr) begin
            tcnt     <= '0;
            level    <= '0;
            level_up <= 1'b0;
        end else begin
            level_up <= 1'b0;
            if (fire) begin
                if (tcnt == TCNT_W'(TICKS_PER_LEVEL - 1)) begin
                    tcnt <= '0;
                    if (level < LEVEL_W'(MAX_LEVEL)) begin
                        level    <= level + LEVEL_W'(1);
                        level_up <= 1'b1;
                    end
                end else begin
                    tcnt <= tcnt + TCNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_game_tick_ctrl.sv
module tb_game_tick_ctrl;

    localparam int P_BASE  = 10;
    localparam int P_STEP  = 2;
    localparam int P_MIN   = 4;
    localparam int P_TPL   = 3;
    localparam int P_MAX   = 3;
    localparam int P_GRACE = 2;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       collision = 1'b0;
    logic       tick;
    logic       level_up;
    logic [3:0] level;
    logic [1:0] state;
    logic       running;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    always #5 clk_in = ~clk_in;

    game_tick_ctrl #(
        .BASE_DIV(P_BASE), .DIV_STEP(P_STEP), .MIN_DIV(P_MIN),
        .TICKS_PER_LEVEL(P_TPL), .MAX_LEVEL(P_MAX), .GRACE_TICKS(P_GRACE)
    ) dut (
        .clk_in(clk_in), .reset(reset), .start(start), .pause(pause),
        .collision(collision), .tick(tick), .level_up(level_up),
        .level(level), .state(state), .running(running)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Period is derived from total ticks since start; level is ticks/TPL clamped.
    int m_state = 0;
    int m_elapsed = 0;
    int m_ticks = 0;
    int m_grace = 0;
    int m_tick = 0;
    int m_lu = 0;

    function automatic int m_level();
        int l;
        l = m_ticks / P_TPL;
        return (l > P_MAX) ? P_MAX : l;
    endfunction

    function automatic int m_period(input int lvl);
        int t;
        t = P_BASE - lvl * P_STEP;
        if (t < P_MIN) t = P_MIN;
        return t + 1;
    endfunction

    always @(posedge clk_in) begin
        bit hit;
        m_tick = 0;
        m_lu = 0;
        if (reset) begin
            m_state = 0; m_elapsed = 0; m_ticks = 0; m_grace = 0;
        end else begin
            case (m_state)
                0, 3: if (start) begin
                    m_state = 1; m_elapsed = 0; m_ticks = 0; m_grace = 0;
                end
                1: begin
`ifdef GAME_GRACE_PERIOD_EN
                    hit = collision && (m_grace >= P_GRACE);
`else
                    hit = collision;
`endif
                    if (hit) m_state = 3;
                    else if (pause) m_state = 2;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == m_period(m_level())) begin
                            m_elapsed = 0;
                            m_ticks++;
                            m_tick = 1;
                            if ((m_ticks % P_TPL == 0) && (m_ticks / P_TPL <= P_MAX)) m_lu = 1;
                            if (m_grace < P_GRACE) m_grace++;
                        end
                    end
                end
                2: if (pause) m_state = 1;
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clk_in) begin
        if (cmp_en) begin
            chk("cyc_tick", int'(tick), m_tick);
            chk("cyc_level_up", int'(level_up), m_lu);
            chk("cyc_level", int'(level), m_level());
            chk("cyc_state", int'(state), m_state);
            chk("cyc_running", int'(running), (m_state == 1) ? 1 : 0);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        @(negedge clk_in);
        pause = 1'b0;
    endtask

    task automatic wait_tick(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!tick && n < max_cyc);
        if (!tick) chk("tick_wait", int'(tick), 1);
    endtask

    task automatic quiet(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_in);
            if (tick) seen++;
        end
        chk(name, seen, 0);
    endtask

    int exp_sp[12] = '{11, 11, 11, 9, 9, 9, 7, 7, 7, 5, 5, 5};

    initial begin
        int n;
        repeat (2) @(negedge clk_in);
        cmp_en = 1'b1;
        chk("rst_state", int'(state), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_tick", int'(tick), 0);
        reset = 1'b0;
        @(negedge clk_in);

        // level progression and saturation
        pulse_start();
        chk("start_state", int'(state), 1);
        chk("start_running", int'(running), 1);
        for (int i = 0; i < 12; i++) begin
            wait_tick(40, n);
            chk($sformatf("spacing_%0d", i + 1), n, exp_sp[i]);
            if (i == 0) chk("lu_t1", int'(level_up), 0);
            if (i == 2) begin
                chk("level_t3", int'(level), 1);
                chk("lu_t3", int'(level_up), 1);
            end
            if (i == 8) chk("level_t9", int'(level), 3);
            if (i == 11) begin
                chk("level_t12", int'(level), 3);
                chk("lu_t12", int'(level_up), 0);
            end
        end

        // pause preserves the partial period
        do_reset();
        pulse_start();
        wait_tick(40, n);
        repeat (4) @(negedge clk_in);
        pulse_pause();
        chk("paused_state", int'(state), 2);
        chk("paused_running", int'(running), 0);
        quiet(19, "pause_no_tick");
        pulse_pause();
        chk("resume_state", int'(state), 1);
        wait_tick(40, n);
        chk("resume_gap", n, 7);
        wait_tick(40, n);
        chk("resume_next", n, 11);

        // collision on the terminal-count cycle
        do_reset();
        pulse_start();
        wait_tick(40, n);
        repeat (10) @(negedge clk_in);
`ifdef GAME_GRACE_PERIOD_EN
        wait_tick(40, n);
        repeat (10) @(negedge clk_in);
`endif
        collision = 1'b1;
        @(negedge clk_in);
        collision = 1'b0;
        chk("over_state", int'(state), 3);
        chk("over_tick", int'(tick), 0);
        quiet(15, "over_no_tick");
        pulse_start();
        chk("restart_state", int'(state), 1);
        chk("restart_level", int'(level), 0);
        wait_tick(40, n);
        chk("restart_gap", n, 11);

        // reset wins over start and collision
        do_reset();
        pulse_start();
        for (int i = 0; i < 6; i++) wait_tick(40, n);
        chk("pre_rst_level", int'(level), 2);
        repeat (3) @(negedge clk_in);
        reset = 1'b1; start = 1'b1; collision = 1'b1;
        @(negedge clk_in);
        reset = 1'b0; start = 1'b0; collision = 1'b0;
        chk("midrst_state", int'(state), 0);
        chk("midrst_level", int'(level), 0);
        chk("midrst_tick", int'(tick), 0);
        @(negedge clk_in);

        // collision held from start
        collision = 1'b1;
        pulse_start();
        chk("hold_state_s1", int'(state), 1);
`ifdef GAME_GRACE_PERIOD_EN
        wait_tick(40, n);
        chk("grace_t1_state", int'(state), 1);
        wait_tick(40, n);
        chk("grace_t2_state", int'(state), 1);
        @(negedge clk_in);
        chk("grace_end_state", int'(state), 3);
`else
        @(negedge clk_in);
        chk("hold_state_s2", int'(state), 3);
`endif
        collision = 1'b0;
        repeat (3) @(negedge clk_in);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
